// File: rtl/out_port_buffer.sv
// Output-port FIFO between the control unit's OUT strobe and a valid/ready consumer.
// Optional same-cycle bypass when empty: define OUT_BUF_BYPASS_EN.
module out_port_buffer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  level,
  output logic              full,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int unsigned IDX_W = CNT_W - 1;

  typedef enum logic [1:0] {
    FILL_EMPTY,
    FILL_PARTIAL,
    FILL_FULL
  } fill_e;

  fill_e             fill_c;
  logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              bypass_c, pop, bypass_pop, push_ok;

  // Fill state decoded from the wrap-extended pointers
  always_comb begin
    wr_idx = wr_ptr_q[IDX_W-1:0];
    rd_idx = rd_ptr_q[IDX_W-1:0];
    fill_c = FILL_PARTIAL;
    if (wr_ptr_q == rd_ptr_q) begin
      fill_c = FILL_EMPTY;
    end else if (wr_idx == rd_idx) begin
      fill_c = FILL_FULL;
    end
  end

  // Output presentation, handshake and next-state
  always_comb begin
    bypass_c = 1'b0;
`ifdef OUT_BUF_BYPASS_EN
    bypass_c = (fill_c == FILL_EMPTY);
`endif
    out_valid = (fill_c != FILL_EMPTY);
    out_data  = (fill_c == FILL_EMPTY) ? '0 : mem_q[rd_idx];
    if (bypass_c) begin
      out_valid = wr_en;
      out_data  = wr_data;
    end

    pop        = out_valid & out_ready;
    // A bypassed word consumed in flight is never written to storage
    bypass_pop = bypass_c & pop;
    push_ok    = wr_en & ((fill_c != FILL_FULL) | pop) & ~bypass_pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + CNT_W'(1);
    end
    if (pop & ~bypass_pop) begin
      rd_ptr_d = rd_ptr_q + CNT_W'(1);
    end

    overflow_d = overflow_q;
    if (wr_en & (fill_c == FILL_FULL) & ~pop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end

    mem_d = mem_q;
    if (push_ok) begin
      mem_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately left unreset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign level    = wr_ptr_q - rd_ptr_q;
  assign full     = (fill_c == FILL_FULL);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_out_port_buffer.sv
// Scoreboard bench for out_port_buffer: a reference queue is updated from the stimulus
// and every cycle's outputs are compared against it.
module tb_out_port_buffer;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [CNT_W-1:0]  level;
  logic              full;
  logic              overflow;
  logic              ovf_clr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] sb_q[$];
  logic              ovf_m;
  int                m_sz;
  logic              m_byp, m_valid, m_pop, m_push;

  out_port_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .level(level), .full(full), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Inputs are stable between posedge+1 and the next posedge; model evaluates at negedge
  always @(negedge clk) begin
    if (rst_n) begin
      m_sz  = sb_q.size();
      m_byp = 1'b0;
`ifdef OUT_BUF_BYPASS_EN
      m_byp = (m_sz == 0);
`endif
      m_valid = m_byp ? wr_en : (m_sz > 0);
      check("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        check("out_data", 32'(out_data), m_byp ? 32'(wr_data) : 32'(sb_q[0]));
      end else if (!m_byp) begin
        check("out_data_empty", 32'(out_data), 32'd0);
      end
      check("level", 32'(level), 32'(m_sz));
      check("full", 32'(full), 32'(m_sz == DEPTH));
      check("overflow", 32'(overflow), 32'(ovf_m));

      m_pop  = m_valid && out_ready;
      m_push = wr_en && (m_sz < DEPTH || m_pop) && !(m_byp && m_pop);
      if (wr_en && m_sz == DEPTH && !m_pop) ovf_m = 1'b1;
      else if (ovf_clr) ovf_m = 1'b0;
      if (m_pop && !m_byp) void'(sb_q.pop_front());
      if (m_push) sb_q.push_back(wr_data);
    end
  end

  task automatic step(input logic we, input logic [DATA_W-1:0] d, input logic rdy,
                      input logic clr);
    wr_en     = we;
    wr_data   = d;
    out_ready = rdy;
    ovf_clr   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && sb_q.size() > 0; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("drain_level", 32'(level), 32'd0);
  endtask

  task automatic fill(input int n, input logic [DATA_W-1:0] base);
    for (int i = 0; i < n; i++) step(1'b1, base + DATA_W'(i), 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    ovf_m = 1'b0;
    #12;
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ordering
    step(1'b1, 16'h1111, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 1'b0, 1'b0);
    step(1'b1, 16'h3333, 1'b0, 1'b0);
    check("t2_level3", 32'(level), 32'd3);
    drain();

    // Overflow, set-over-clear priority, then clear
    fill(DEPTH + 1, 16'h3000);
    check("t3_level", 32'(level), 32'(DEPTH));
    check("t3_full", 32'(full), 32'd1);
    check("t3_ovf", 32'(overflow), 32'd1);
    step(1'b1, 16'hDEAD, 1'b0, 1'b1);
    check("t3_ovf_prio", 32'(overflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    check("t3_ovf_clr", 32'(overflow), 32'd0);
    drain();

    // Async reset mid-stream with level 3 and overflow set
    fill(DEPTH + 1, 16'h4000);
    for (int i = 0; i < DEPTH - 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("t1_pre_level", 32'(level), 32'd3);
    rst_n = 1'b0;
    sb_q.delete();
    ovf_m = 1'b0;
    #1;
    check("t1_level", 32'(level), 32'd0);
    check("t1_valid", 32'(out_valid), 32'd0);
    check("t1_ovf", 32'(overflow), 32'd0);
    wr_en = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full with simultaneous push and pop
    fill(DEPTH, 16'h5000);
    step(1'b1, 16'hBEEF, 1'b1, 1'b0);
    check("t4_level", 32'(level), 32'(DEPTH));
    check("t4_ovf", 32'(overflow), 32'd0);
    drain();

    // Backpressure with continuous pushes
    for (int i = 0; i < 32; i++)
      step(1'b1, DATA_W'($urandom_range(0, 16'hFFFF)), (i % 2) == 0, 1'b0);
    drain();

    // Random traffic
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), DATA_W'($urandom_range(0, 16'hFFFF)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
    drain();
    step(1'b0, '0, 1'b0, 1'b1);

    // Empty buffer, push with consumer ready
    wr_en = 1'b1; wr_data = 16'hA5A5; out_ready = 1'b1; ovf_clr = 1'b0;
    #1;
`ifdef OUT_BUF_BYPASS_EN
    check("t6_same_valid", 32'(out_valid), 32'd1);
    check("t6_same_data", 32'(out_data), 32'hA5A5);
    @(posedge clk); #1;
    check("t6_level", 32'(level), 32'd0);
`else
    check("t6_same_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("t6_next_valid", 32'(out_valid), 32'd1);
    check("t6_next_data", 32'(out_data), 32'hA5A5);
`endif
    step(1'b0, '0, 1'b1, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
